// File: rtl/rs422_rx_axis.sv
// rs422_rx_axis: RS422 serial receiver to AXI-Stream bytes.
// Synchronises the asynchronous link (rs422_clk, rs422_cs, rs422_data), rebuilds
// MSB-first bytes, tags the last byte of each chip-select frame with tlast and
// buffers {tlast, tdata} in a first-word-fall-through FIFO.
// Optional build macro RS422_RX_GLITCH_FILTER_EN inserts a 3-sample majority
// filter on rs422_clk and rs422_cs (data is delayed to stay aligned).
module rs422_rx_axis #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rs422_clk,
    input  logic       rs422_cs,
    input  logic       rs422_data,
    output logic       tvalid,
    input  logic       tready,
    output logic [7:0] tdata,
    output logic       tlast,
    output logic       frame_err,
    output logic       overflow
);

    // Line vector ordering {data, cs, clk}; idle is clk=1, cs=1, data=0.
    localparam logic [2:0] LINE_IDLE = 3'b011;
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(FIFO_DEPTH);

    logic [2:0] line_pin;
    logic [2:0] sync1_reg;
    logic [2:0] sync2_reg;

    assign line_pin = {rs422_data, rs422_cs, rs422_clk};

    // Two-flop synchroniser for all three line inputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_reg <= LINE_IDLE;
            sync2_reg <= LINE_IDLE;
        end else begin
            sync1_reg <= line_pin;
            sync2_reg <= sync1_reg;
        end
    end

    logic [1:0] ctl_line;   // {cs, clk} after optional filtering
    logic       data_line;  // data aligned with ctl_line edges

`ifdef RS422_RX_GLITCH_FILTER_EN
    // Startup cycles before the edge detector sees real line levels.
    localparam logic [2:0] WARM_CYCLES = 3'd5;

    logic data_d1_reg;
    logic data_d2_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filt
            logic tap0_reg;
            logic tap1_reg;
            logic filt_reg;
            // Majority of the current synchronised sample and two previous ones
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    tap0_reg <= LINE_IDLE[gi];
                    tap1_reg <= LINE_IDLE[gi];
                    filt_reg <= LINE_IDLE[gi];
                end else begin
                    tap0_reg <= sync2_reg[gi];
                    tap1_reg <= tap0_reg;
                    filt_reg <= (sync2_reg[gi] & tap0_reg) | (sync2_reg[gi] & tap1_reg) |
                                (tap0_reg & tap1_reg);
                end
            end
            assign ctl_line[gi] = filt_reg;
        end
    endgenerate

    // Delay data by the filter latency so the sampled bit stays on its edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_d1_reg <= 1'b0;
            data_d2_reg <= 1'b0;
        end else begin
            data_d1_reg <= sync2_reg[2];
            data_d2_reg <= data_d1_reg;
        end
    end
    assign data_line = data_d2_reg;
`else
    localparam logic [2:0] WARM_CYCLES = 3'd3;

    assign ctl_line  = sync2_reg[1:0];
    assign data_line = sync2_reg[2];
`endif

    logic [1:0] ctl_d_reg;
    logic [2:0] warm_cnt_reg;
    logic       warm_done;

    // Edge-detect stage and startup counter. The counter keeps the idle reset
    // value of the pipeline from looking like a cs falling edge when cs is
    // already low at reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctl_d_reg    <= LINE_IDLE[1:0];
            warm_cnt_reg <= 3'd0;
        end else begin
            ctl_d_reg <= ctl_line;
            if (!warm_done) begin
                warm_cnt_reg <= warm_cnt_reg + 3'd1;
            end
        end
    end

    logic cs_sync;
    logic clk_rise;
    logic cs_fall;
    logic cs_rise;

    assign warm_done = (warm_cnt_reg == WARM_CYCLES);
    assign cs_sync   = ctl_line[1];
    assign clk_rise  = ctl_line[0] & ~ctl_d_reg[0];
    assign cs_fall   = ~ctl_line[1] & ctl_d_reg[1];
    assign cs_rise   = ctl_line[1] & ~ctl_d_reg[1];

    // Deserialiser state. The shift register keeps the 7 most recent bits;
    // the 8th bit goes straight into the hold byte together with them.
    logic       in_frame_reg,   in_frame_next;
    logic [2:0] bit_cnt_reg,    bit_cnt_next;
    logic [6:0] shift_reg,      shift_next;
    logic [7:0] hold_reg,       hold_next;
    logic       hold_valid_reg, hold_valid_next;
    logic       frame_err_reg,  frame_err_next;
    logic       wr_en;
    logic       wr_last;
    logic [7:0] capture_byte;

    assign capture_byte = {shift_reg, data_line};

    // Frame start/end and bit capture; a held byte is released either by the
    // next complete byte (tlast=0) or by the frame end (tlast=1)
    always_comb begin
        in_frame_next   = in_frame_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        hold_next       = hold_reg;
        hold_valid_next = hold_valid_reg;
        frame_err_next  = 1'b0;
        wr_en           = 1'b0;
        wr_last         = 1'b0;
        if (cs_fall && warm_done) begin
            in_frame_next   = 1'b1;
            bit_cnt_next    = 3'd0;
            hold_valid_next = 1'b0;
        end else if (in_frame_reg && cs_rise) begin
            wr_en           = hold_valid_reg;
            wr_last         = 1'b1;
            frame_err_next  = (bit_cnt_reg != 3'd0);
            in_frame_next   = 1'b0;
            hold_valid_next = 1'b0;
            bit_cnt_next    = 3'd0;
        end else if (in_frame_reg && !cs_sync && clk_rise) begin
            shift_next   = capture_byte[6:0];
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
                wr_en           = hold_valid_reg;
                hold_next       = capture_byte;
                hold_valid_next = 1'b1;
            end
        end
    end

    // Deserialiser state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_frame_reg   <= 1'b0;
            bit_cnt_reg    <= 3'd0;
            shift_reg      <= 7'd0;
            hold_reg       <= 8'd0;
            hold_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            in_frame_reg   <= in_frame_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            hold_reg       <= hold_next;
            hold_valid_reg <= hold_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    // Output FIFO, first-word-fall-through
    logic [8:0]         fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic [FIFO_AW:0]   count_reg;
    logic [8:0]         head;
    logic               full;
    logic               rd_en;
    logic               push;
    logic               drop;
    logic               overflow_reg;

    assign full  = (count_reg == FULL_COUNT);
    assign rd_en = tvalid & tready;
    // A read in the same cycle frees the slot, so a write when full succeeds
    assign push  = wr_en & (~full | rd_en);
    assign drop  = wr_en & full & ~rd_en;
    assign head  = fifo_mem[rd_ptr_reg];

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {wr_last, hold_reg};
        end
    end

    // FIFO pointers, occupancy and overflow pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= drop;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !rd_en) begin
                count_reg <= count_reg + 1'b1;
            end else if (!push && rd_en) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Head entry is masked while empty so outputs read zero after reset
    assign tvalid    = (count_reg != '0);
    assign tdata     = tvalid ? head[7:0] : 8'h00;
    assign tlast     = tvalid & head[8];
    assign frame_err = frame_err_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_rs422_rx_axis.sv
// tb_rs422_rx_axis: directed bench for rs422_rx_axis with an expected-beat queue.
module tb_rs422_rx_axis;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rs422_clk = 1'b1;
    logic       rs422_cs = 1'b1;
    logic       rs422_data = 1'b0;
    logic       tready = 1'b0;
    logic       tvalid;
    logic [7:0] tdata;
    logic       tlast;
    logic       frame_err;
    logic       overflow;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;
    int ferr_cycles = 0;
    int ovf_cycles = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_exp;

    rs422_rx_axis #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rs422_clk  (rs422_clk),
        .rs422_cs   (rs422_cs),
        .rs422_data (rs422_data),
        .tvalid     (tvalid),
        .tready     (tready),
        .tdata      (tdata),
        .tlast      (tlast),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream monitor on the falling edge: beats, frame_err and overflow pulses
    always @(negedge clk) begin
        if (rstn) begin
            if (frame_err) ferr_cycles++;
            if (overflow) ovf_cycles++;
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(tvalid), 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    $display("beat tdata=%02h tlast=%0d expected %02h/%0d",
                             tdata, tlast, mon_exp[7:0], mon_exp[8]);
                    chk("beat_data", 32'(tdata), 32'(mon_exp[7:0]));
                    chk("beat_last", 32'(tlast), 32'(mon_exp[8]));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rs422_data = b;
        rs422_clk  = 1'b0;
        tick(2);
        rs422_clk  = 1'b1;
        tick(2);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic frame_start();
        rs422_cs = 1'b0;
        tick(4);
    endtask

    task automatic frame_end();
        tick(2);
        rs422_cs = 1'b1;
        tick(10);
    endtask

    task automatic wait_drain(input string tag);
        for (int n = 0; n < 400 && exp_q.size() != 0; n++) tick(1);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(3);
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tdata", 32'(tdata), 32'd0);
        chk("rst_tlast", 32'(tlast), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rstn = 1'b1;
        tick(8);

        // Two-byte frame
        tready = 1'b1;
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b1, 8'h3C});
        frame_start();
        send_byte(8'hA5);
        send_byte(8'h3C);
        frame_end();
        wait_drain("two_byte_drain");
        chk("two_byte_ferr", 32'(ferr_cycles), 32'd0);
        chk("two_byte_ovf", 32'(ovf_cycles), 32'd0);

        // Single-byte frame: nothing appears before the frame end
        exp_q.push_back({1'b1, 8'h81});
        frame_start();
        send_byte(8'h81);
        tick(6);
        chk("single_before_end", 32'(tvalid), 32'd0);
        frame_end();
        wait_drain("single_drain");

        // 8+5 bits: partial byte discarded with a one-cycle frame_err
        ferr_cycles = 0;
        exp_q.push_back({1'b1, 8'hFF});
        frame_start();
        send_byte(8'hFF);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        frame_end();
        wait_drain("partial_drain");
        chk("partial_ferr_cycles", 32'(ferr_cycles), 32'd1);
        chk("partial_ovf", 32'(ovf_cycles), 32'd0);

        // Overflow: 18 bytes into a 16-entry FIFO with tready low
        tready = 1'b0;
        ferr_cycles = 0;
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, 8'(i)});
        frame_start();
        for (int i = 0; i < 18; i++) send_byte(8'(i));
        frame_end();
        chk("ovf_pulses", 32'(ovf_cycles), 32'd2);
        chk("ovf_full_valid", 32'(tvalid), 32'd1);
        chk("ovf_head", 32'(tdata), 32'h00);
        tready = 1'b1;
        wait_drain("ovf_drain");
        tick(1);
        chk("ovf_empty", 32'(tvalid), 32'd0);

        // Reset mid-byte with cs held low
        tready = 1'b0;
        ovf_cycles = 0;
        frame_start();
        send_byte(8'h11);
        send_byte(8'h22);
        send_bit(1'b1); send_bit(1'b0);
        chk("pre_rst_valid", 32'(tvalid), 32'd1);
        chk("pre_rst_data", 32'(tdata), 32'h11);
        rstn = 1'b0;
        #1;
        chk("mid_rst_tvalid", 32'(tvalid), 32'd0);
        chk("mid_rst_tdata", 32'(tdata), 32'd0);
        chk("mid_rst_tlast", 32'(tlast), 32'd0);
        tick(2);
        rstn = 1'b1;
        tready = 1'b1;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_byte(8'h33);
        frame_end();
        chk("post_rst_silent", 32'(tvalid), 32'd0);
        chk("post_rst_ferr", 32'(ferr_cycles), 32'd0);
        exp_q.push_back({1'b1, 8'h5A});
        frame_start();
        send_byte(8'h5A);
        frame_end();
        wait_drain("post_rst_drain");

        // One-cycle cs glitch between bytes
`ifdef RS422_RX_GLITCH_FILTER_EN
        exp_q.push_back({1'b0, 8'h12});
`else
        exp_q.push_back({1'b1, 8'h12});
`endif
        exp_q.push_back({1'b1, 8'h34});
        frame_start();
        send_byte(8'h12);
        tick(2);
        rs422_cs = 1'b1;
        tick(1);
        rs422_cs = 1'b0;
        tick(8);
        send_byte(8'h34);
        frame_end();
        wait_drain("glitch_drain");
        chk("glitch_ferr", 32'(ferr_cycles), 32'd0);
        chk("glitch_ovf", 32'(ovf_cycles), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
